reg_read_scoreboard: RTL



---
 rtl/reg_read_scoreboard_pkg.sv | 13 +
 rtl/reg_read_scoreboard_if.sv | 46 ++++
 rtl/reg_busy_counters.sv | 68 ++++++
 rtl/reg_read_scoreboard.sv | 123 ++++++++++++
 4 files changed

// File: rtl/reg_read_scoreboard_pkg.sv
// Shared types and constants for the register-read issue scoreboard.
package reg_read_scoreboard_pkg;

    localparam int unsigned RegCount = 32;

    typedef logic [4:0] reg_index_t;

    typedef enum logic [0:0] {
        StRun,
        StSerial
    } sb_state_e;

endpackage

// File: rtl/reg_read_scoreboard_if.sv
// RR-stage request, retire ports and stall/issue handshake of the scoreboard.
interface reg_read_scoreboard_if;
    import reg_read_scoreboard_pkg::*;

    // Op in the RR stage
    logic       rr_valid;
    reg_index_t rr_rs1;
    reg_index_t rr_rs2;
    reg_index_t rr_rs3;
    logic       rr_read_int1;
    logic       rr_read_int2;
    logic       rr_read_fp1;
    logic       rr_read_fp2;
    logic       rr_read_fp3;
    reg_index_t rr_rd;
    logic       rr_write_int;
    logic       rr_write_fp;
    logic       rr_serialize;
    logic       ex_stall;
    logic       flush;

    // Retire ports: 0 = int pipe, 1 = fp pipe
    logic [1:0]       ret_valid;
    reg_index_t [1:0] ret_rd;
    logic [1:0]       ret_write_int;
    logic [1:0]       ret_write_fp;

    // Handshake back to the pipe controller
    logic rr_stall;
    logic issue;

    modport master (
        output rr_valid, rr_rs1, rr_rs2, rr_rs3, rr_read_int1, rr_read_int2,
               rr_read_fp1, rr_read_fp2, rr_read_fp3, rr_rd, rr_write_int, rr_write_fp,
               rr_serialize, ex_stall, flush, ret_valid, ret_rd, ret_write_int, ret_write_fp,
        input  rr_stall, issue
    );

    modport slave (
        input  rr_valid, rr_rs1, rr_rs2, rr_rs3, rr_read_int1, rr_read_int2,
               rr_read_fp1, rr_read_fp2, rr_read_fp3, rr_rd, rr_write_int, rr_write_fp,
               rr_serialize, ex_stall, flush, ret_valid, ret_rd, ret_write_int, ret_write_fp,
        output rr_stall, issue
    );

endinterface

// File: rtl/reg_busy_counters.sv
// Bank of 32 pending-write counters: one increment and two decrement ports per cycle.
module reg_busy_counters
    import reg_read_scoreboard_pkg::*;
#(
    parameter int unsigned CntWidth = 2,
    parameter bit          MaskZero = 1'b0  // entry 0 is hardwired to zero (int x0)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          inc_en_i,
    input  reg_index_t                    inc_idx_i,
    input  logic [1:0]                    dec_en_i,
    input  reg_index_t [1:0]              dec_idx_i,
    input  reg_index_t [2:0]              rd_idx_i,
    output logic [2:0][CntWidth-1:0]      rd_cnt_o,
    input  reg_index_t                    dst_idx_i,
    output logic [CntWidth-1:0]           dst_cnt_o,
    output logic                          underflow_o
);

    // One extra bit so count + increment cannot wrap before clamping.
    localparam int unsigned SumWidth = CntWidth + 1;
    localparam logic [SumWidth-1:0] CntMax = SumWidth'({CntWidth{1'b1}});

    logic [RegCount-1:0][CntWidth-1:0] cnt_q, cnt_d;

    // Net per-entry update: increment and both decrements are summed, clamped at zero.
    always_comb begin
        logic [SumWidth-1:0] up;
        logic [SumWidth-1:0] down;
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        for (int unsigned i = 0; i < RegCount; i++) begin
            up   = SumWidth'(cnt_q[i])
                 + SumWidth'(inc_en_i && (inc_idx_i == reg_index_t'(i)));
            down = SumWidth'(dec_en_i[0] && (dec_idx_i[0] == reg_index_t'(i)))
                 + SumWidth'(dec_en_i[1] && (dec_idx_i[1] == reg_index_t'(i)));
            if (MaskZero && i == 0) begin
                cnt_d[i] = '0;
            end else if (down > up) begin
                cnt_d[i]    = '0;
                underflow_o = 1'b1;
            end else if ((up - down) > CntMax) begin
                cnt_d[i] = CntMax[CntWidth-1:0];
            end else begin
                cnt_d[i] = CntWidth'(up - down);
            end
        end
    end

    // Counter storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read-out of sources and destination
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            rd_cnt_o[k] = cnt_q[rd_idx_i[k]];
        end
        dst_cnt_o = cnt_q[dst_idx_i];
    end

endmodule

// File: rtl/reg_read_scoreboard.sv
// Issue interlock for the RR stage: register hazards, in-flight limit and serialization.
module reg_read_scoreboard
    import reg_read_scoreboard_pkg::*;
#(
    parameter int unsigned  MaxInflight = 16,
    parameter int unsigned  CntWidth    = 2,
    localparam int unsigned InFlightW   = $clog2(MaxInflight) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    reg_read_scoreboard_if.slave   bus,
    output logic [InFlightW-1:0]   in_flight_o,
    output logic                   underflow_o
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    sb_state_e               state_q, state_d;
    logic [InFlightW-1:0]    in_flight_q, in_flight_d;
    logic                    underflow_q;
    logic                    in_flight_uf;
    logic [2:0][CntWidth-1:0] int_cnt, fp_cnt;
    logic [CntWidth-1:0]     int_dst_cnt, fp_dst_cnt;
    logic                    int_uf, fp_uf;
    logic                    hazard, saturation, full, stall;

    reg_busy_counters #(
        .CntWidth (CntWidth),
        .MaskZero (1'b1)
    ) u_int_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_en_i    (bus.issue & bus.rr_write_int),
        .inc_idx_i   (bus.rr_rd),
        .dec_en_i    (bus.ret_valid & bus.ret_write_int),
        .dec_idx_i   (bus.ret_rd),
        .rd_idx_i    ({bus.rr_rs3, bus.rr_rs2, bus.rr_rs1}),
        .rd_cnt_o    (int_cnt),
        .dst_idx_i   (bus.rr_rd),
        .dst_cnt_o   (int_dst_cnt),
        .underflow_o (int_uf)
    );

    reg_busy_counters #(
        .CntWidth (CntWidth),
        .MaskZero (1'b0)
    ) u_fp_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_en_i    (bus.issue & bus.rr_write_fp),
        .inc_idx_i   (bus.rr_rd),
        .dec_en_i    (bus.ret_valid & bus.ret_write_fp),
        .dec_idx_i   (bus.ret_rd),
        .rd_idx_i    ({bus.rr_rs3, bus.rr_rs2, bus.rr_rs1}),
        .rd_cnt_o    (fp_cnt),
        .dst_idx_i   (bus.rr_rd),
        .dst_cnt_o   (fp_dst_cnt),
        .underflow_o (fp_uf)
    );

    // Int ops have no third source
    logic unused_int_rs3;
    assign unused_int_rs3 = ^int_cnt[2];

    // Stall decision: registered state plus RR/EX inputs only, never the retire ports.
    always_comb begin
        hazard = (bus.rr_read_int1 && int_cnt[0] != '0) ||
                 (bus.rr_read_int2 && int_cnt[1] != '0) ||
                 (bus.rr_read_fp1  && fp_cnt[0]  != '0) ||
                 (bus.rr_read_fp2  && fp_cnt[1]  != '0) ||
                 (bus.rr_read_fp3  && fp_cnt[2]  != '0);
        saturation = (bus.rr_write_int && int_dst_cnt == CntMax) ||
                     (bus.rr_write_fp  && fp_dst_cnt  == CntMax);
        full  = (in_flight_q == InFlightW'(MaxInflight));
        stall = 1'b0;
        unique case (state_q)
            StRun: stall = bus.rr_valid && (hazard || saturation || full || bus.ex_stall ||
                                            (bus.rr_serialize && in_flight_q != '0));
            StSerial: stall = bus.rr_valid;
            default: stall = bus.rr_valid;
        endcase
    end

    assign bus.rr_stall = stall;
    assign bus.issue    = bus.rr_valid & ~stall & ~bus.flush;

    // In-flight count: issue and both retires summed, clamped at zero.
    always_comb begin
        logic [InFlightW-1:0] up;
        logic [InFlightW-1:0] down;
        up   = in_flight_q + InFlightW'(bus.issue);
        down = InFlightW'(bus.ret_valid[0]) + InFlightW'(bus.ret_valid[1]);
        in_flight_uf = (down > up);
        in_flight_d  = in_flight_uf ? '0 : up - down;
    end

    // Next state: leave SERIAL as the count drains so the following cycle can issue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (bus.issue && bus.rr_serialize) state_d = StSerial;
            StSerial: if (in_flight_d == '0) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // State, in-flight count and sticky underflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            in_flight_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            underflow_q <= underflow_q | int_uf | fp_uf | in_flight_uf;
        end
    end

    assign in_flight_o = in_flight_q;
    assign underflow_o = underflow_q;

endmodule
